pwl_exp_arb: RTL and testbench
==============================

PWL_EXP_ARB -- requirements
Module: pwl_exp_arb

Interface
REQ-001 Parameter DW, default 16: FP16 data width of frac, y0, slope and result.
REQ-002 Parameter NREQ, default 4: number of requesters sharing one PWL ROM plus MAC.
REQ-003 Parameter MAC_LAT, default 3: fixed MAC latency in cycles, mac_valid_o to mac_valid_i; legal range 1..8.
REQ-004 Port clk, input, 1: clock; all state on the rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 Port en_i, input, 1: grant enable; 0 blocks new grants, in-flight work completes.
REQ-007 Port flush_i, input, 1: discard all in-flight work and reset the round-robin pointer.
REQ-008 Port req_valid_i, input, NREQ: per-requester request valid.
REQ-009 Port req_ready_o, output, NREQ: per-requester grant, one-hot or zero.
REQ-010 Port req_seg_i, input, 3*NREQ: packed segment index, requester k at bits [3k+2:3k].
REQ-011 Port req_frac_i, input, DW*NREQ: packed FP16 fractional operand, requester k at slice k.
REQ-012 Port rom_valid_o / rom_seg_o, outputs, 1 / 3: request to the shared PWL ROM.
REQ-013 Port rom_valid_i / rom_y0_i / rom_slope_i, inputs, 1 / DW / DW: ROM response, exactly 1 cycle after rom_valid_o.
REQ-014 Port mac_valid_o / mac_a_o / mac_b_o / mac_c_o, outputs, 1 / DW / DW / DW: MAC issue, computing a*b+c with a=slope, b=frac, c=y0.
REQ-015 Port mac_valid_i / mac_res_i, inputs, 1 / DW: MAC result.
REQ-016 Port res_valid_o / res_data_o, outputs, NREQ / DW: result pulse to the owning requester; res_data_o is shared.
REQ-017 Port busy_o, output, 1: at least one operation is in flight.
REQ-018 Port err_o, output, 1: sticky protocol error.

Function
REQ-019 Handshake: a request transfers in the cycle where req_valid_i[k] and req_ready_o[k] are both 1; no backpressure on results.
REQ-020 Grant: req_ready_o is combinational; it is nonzero only when en_i=1 and flush_i=0, and it selects the first valid requester at or after pointer rr_ptr, wrapping modulo NREQ.
REQ-021 Pointer: after a grant to k, rr_ptr becomes (k+1) mod NREQ; with no grant it holds; flush_i sets it to 0.
REQ-022 Issue: in the grant cycle, rom_valid_o=1 and rom_seg_o equals the granted seg, both combinational; at most one issue per cycle.
REQ-023 Stage 1: the granted frac and tag (log2 NREQ bits) are registered once, aligned with the ROM response.
REQ-024 MAC drive: mac_valid_o=rom_valid_i AND stage-1 valid; mac_a_o=rom_slope_i, mac_b_o=stage-1 frac, mac_c_o=rom_y0_i.
REQ-025 Tag pipe: a valid+tag shift register of MAC_LAT stages, loaded on mac_valid_o, is aligned with mac_valid_i.
REQ-026 Routing: on mac_valid_i with tag-pipe output valid, res_valid_o[tag]=1 and res_data_o=mac_res_i, both registered; total latency from grant to res_valid_o is MAC_LAT+2 cycles.
REQ-027 Throughput: one result per cycle is sustained with all requesters continuously valid.
REQ-028 Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive grants.
REQ-029 Flush: flush_i clears stage 1 and the tag pipe in the same edge; later mac_valid_i pulses for flushed work are dropped silently and do not set err_o.
REQ-030 Drop window: err_o is not set for MAC_LAT+1 cycles after a flush.
REQ-031 Error, set 1: rom_valid_i=1 with stage-1 valid=0, or the reverse, sets err_o.
REQ-032 Error, set 2: mac_valid_i differing from tag-pipe output valid outside the post-flush window sets err_o.
REQ-033 Error clear: err_o clears only on reset.
REQ-034 busy_o=1 while stage 1 or any tag-pipe stage is valid, or res_valid_o is nonzero.
REQ-035 Simultaneous grant and flush cannot occur, because flush_i forces req_ready_o to 0.

Reset
REQ-036 While rstn=0, all registered state is cleared asynchronously: rr_ptr=0, stage-1 and tag-pipe valids 0, res_valid_o=0, res_data_o=0, err_o=0; busy_o is therefore 0.
REQ-037 While rstn=0, req_ready_o, rom_valid_o and mac_valid_o are 0.
REQ-038 Reset mid-operation abandons in-flight work; results returning after rstn deasserts raise err_o per REQ-032.

Verification
REQ-039 Single request: req 2, seg=3, frac=0x3800, MAC_LAT=3 -> rom_seg_o=3 in the grant cycle; mac a/b/c = 0x3B83/0x3800/0x3D30 at +1; res_valid_o[2] with the MAC result at +5.
REQ-040 All four requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each res_valid_o bit pulses twice, in the same order, back-to-back.
REQ-041 Requesters 1 and 3 valid with rr_ptr=2 -> grant 3, then 1; rr_ptr ends at 2.
REQ-042 flush_i asserted 2 cycles after three grants -> no res_valid_o for those grants, err_o stays 0, rr_ptr=0, busy_o falls after the drop window.
REQ-043 Inject mac_valid_i with the tag pipe empty and no prior flush -> err_o=1 and stays 1 until rstn is asserted.
REQ-044 en_i=0 with requests pending -> req_ready_o=0 and in-flight results still delivered; rstn pulsed mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwl_exp_arb_if.sv
// rtl/pwl_exp_arb_if.sv - requester, ROM, MAC and result signals of pwl_exp_arb
//
// Purpose: groups the request/grant handshake, the shared PWL ROM request and
//   response, the MAC issue and return, and the result pulses into one bundle.
// Modports:
//   slave  - arbiter view (drives req_ready_o, rom_*_o, mac_*_o, res_*_o)
//   master - environment view (requesters, ROM and MAC models)
interface pwl_exp_arb_if #(
  parameter int DW   = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [3*NREQ-1:0]  req_seg_i;
  logic [DW*NREQ-1:0] req_frac_i;

  logic               rom_valid_o;
  logic [2:0]         rom_seg_o;
  logic               rom_valid_i;
  logic [DW-1:0]      rom_y0_i;
  logic [DW-1:0]      rom_slope_i;

  logic               mac_valid_o;
  logic [DW-1:0]      mac_a_o;
  logic [DW-1:0]      mac_b_o;
  logic [DW-1:0]      mac_c_o;
  logic               mac_valid_i;
  logic [DW-1:0]      mac_res_i;

  logic [NREQ-1:0]    res_valid_o;
  logic [DW-1:0]      res_data_o;

  modport slave (
    input  req_valid_i, req_seg_i, req_frac_i,
    input  rom_valid_i, rom_y0_i, rom_slope_i,
    input  mac_valid_i, mac_res_i,
    output req_ready_o, rom_valid_o, rom_seg_o,
    output mac_valid_o, mac_a_o, mac_b_o, mac_c_o,
    output res_valid_o, res_data_o
  );

  modport master (
    output req_valid_i, req_seg_i, req_frac_i,
    output rom_valid_i, rom_y0_i, rom_slope_i,
    output mac_valid_i, mac_res_i,
    input  req_ready_o, rom_valid_o, rom_seg_o,
    input  mac_valid_o, mac_a_o, mac_b_o, mac_c_o,
    input  res_valid_o, res_data_o
  );
endinterface

// File: rtl/pwl_exp_arb.sv
// rtl/pwl_exp_arb.sv - round-robin arbiter sharing one PWL ROM and MAC among requesters
//
// Purpose: grants one requester per cycle (round-robin), looks up y0/slope in
//   the shared ROM, issues slope*frac+y0 to the shared MAC and routes the
//   result back to the owning requester MAC_LAT+2 cycles after the grant.
// Ports:
//   clk, rstn - clock, asynchronous active-low reset
//   en_i      - allow new grants (in-flight work always completes)
//   flush_i   - drop all in-flight work, reset the round-robin pointer
//   bus       - pwl_exp_arb_if.slave: request/grant, ROM, MAC and result signals
//   busy_o    - some operation in flight
//   err_o     - sticky protocol error (ROM or MAC response misaligned)
module pwl_exp_arb #(
  parameter int DW      = 16,
  parameter int NREQ    = 4,
  parameter int MAC_LAT = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en_i,
  input  logic               flush_i,
  pwl_exp_arb_if.slave       bus,
  output logic               busy_o,
  output logic               err_o
);

  localparam int TW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DCW = 4;

  function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= NREQ) s = s - NREQ;
    return TW'(s);
  endfunction

  logic [TW-1:0]     r_rr_ptr;
  logic              r_s1_valid;
  logic [DW-1:0]     r_s1_frac;
  logic [TW-1:0]     r_s1_tag;
  logic [MAC_LAT-1:0] r_tp_valid;
  logic [TW-1:0]     r_tp_tag [MAC_LAT];
  logic [NREQ-1:0]   r_res_valid;
  logic [DW-1:0]     r_res_data;
  logic [DCW-1:0]    r_drop_cnt;
  logic              r_err;

  logic              w_gnt_en;
  logic              w_gnt_any;
  logic [TW-1:0]     w_gnt_idx;
  logic [TW-1:0]     w_cand;
  logic [NREQ-1:0]   w_gnt;
  logic [DW-1:0]     w_gnt_frac;
  logic              w_mac_valid;
  logic              w_tp_out_valid;
  logic [TW-1:0]     w_tp_out_tag;
  logic              w_in_drop;
  logic              w_err_s1;
  logic              w_err_tp;

  // Search from the pointer upward, wrapping; first valid requester wins.
  // rstn is folded in so no grant is visible while reset is held.
  always_comb begin
    w_gnt_en  = en_i & ~flush_i & rstn;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_gnt     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = wrap_add(r_rr_ptr, i);
      if (w_gnt_en && !w_gnt_any && bus.req_valid_i[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_frac      = bus.req_frac_i[DW*w_gnt_idx +: DW];
  assign bus.req_ready_o = w_gnt;
  assign bus.rom_valid_o = w_gnt_any;
  assign bus.rom_seg_o   = w_gnt_any ? bus.req_seg_i[3*w_gnt_idx +: 3] : 3'd0;

  // Stage 1 lines the granted operand up with the ROM response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_frac  <= '0;
      r_s1_tag   <= '0;
    end else if (flush_i) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_rr_ptr  <= wrap_add(w_gnt_idx, 1);
        r_s1_frac <= w_gnt_frac;
        r_s1_tag  <= w_gnt_idx;
      end
    end
  end

  assign w_mac_valid     = bus.rom_valid_i & r_s1_valid;
  assign bus.mac_valid_o = w_mac_valid;
  assign bus.mac_a_o     = bus.rom_slope_i;
  assign bus.mac_b_o     = r_s1_frac;
  assign bus.mac_c_o     = bus.rom_y0_i;

  // Tag pipe mirrors the MAC latency so the last stage lines up with mac_valid_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tp_valid <= '0;
      for (int i = 0; i < MAC_LAT; i++) r_tp_tag[i] <= '0;
    end else if (flush_i) begin
      r_tp_valid <= '0;
    end else begin
      r_tp_valid[0] <= w_mac_valid;
      r_tp_tag[0]   <= r_s1_tag;
      for (int i = 1; i < MAC_LAT; i++) begin
        r_tp_valid[i] <= r_tp_valid[i-1];
        r_tp_tag[i]   <= r_tp_tag[i-1];
      end
    end
  end

  assign w_tp_out_valid = r_tp_valid[MAC_LAT-1];
  assign w_tp_out_tag   = r_tp_tag[MAC_LAT-1];

  // A result arriving on the flush edge belongs to discarded work.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= '0;
      if (!flush_i && bus.mac_valid_i && w_tp_out_valid) begin
        r_res_valid[w_tp_out_tag] <= 1'b1;
        r_res_data                <= bus.mac_res_i;
      end
    end
  end

  assign bus.res_valid_o = r_res_valid;
  assign bus.res_data_o  = r_res_data;

  // MAC returns for flushed work keep arriving for MAC_LAT+1 cycles; they are
  // not checked against the (already cleared) tag pipe during that window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_drop_cnt <= DCW'(MAC_LAT + 1);
    end else if (r_drop_cnt != '0) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  assign w_in_drop = flush_i | (r_drop_cnt != '0);
  assign w_err_s1  = bus.rom_valid_i ^ r_s1_valid;
  assign w_err_tp  = (bus.mac_valid_i ^ w_tp_out_valid) & ~w_in_drop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_err_s1 || w_err_tp) begin
      r_err <= 1'b1;
    end
  end

  assign err_o  = r_err;
  assign busy_o = r_s1_valid | (|r_tp_valid) | (|r_res_valid);

endmodule

// File: tb/tb_pwl_exp_arb.sv
// tb/tb_pwl_exp_arb.sv - directed self-checking bench for pwl_exp_arb
module tb_pwl_exp_arb;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic flush;
  logic busy;
  logic err;
  logic inj_mac = 1'b0;
  logic inj_rom = 1'b0;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pwl_exp_arb_if #(.DW(16), .NREQ(4)) bus ();

  pwl_exp_arb #(.DW(16), .NREQ(4), .MAC_LAT(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (en),
    .flush_i (flush),
    .bus     (bus),
    .busy_o  (busy),
    .err_o   (err)
  );

  function automatic logic [15:0] rom_y0(input logic [2:0] s);
    case (s)
      3'd0:    return 16'h3C00;
      3'd1:    return 16'h3C40;
      3'd2:    return 16'h3C80;
      3'd3:    return 16'h3D30;
      default: return 16'h3E00;
    endcase
  endfunction

  function automatic logic [15:0] rom_slope(input logic [2:0] s);
    case (s)
      3'd0:    return 16'h3A00;
      3'd1:    return 16'h3A10;
      3'd2:    return 16'h3A20;
      3'd3:    return 16'h3B83;
      default: return 16'h3B00;
    endcase
  endfunction

  // Requester k uses seg=k and frac=0x1000*(k+1); the MAC model returns a+b+c.
  function automatic logic [15:0] exp_res(input int k);
    logic [2:0]  s;
    logic [15:0] f;
    s = 3'(k);
    f = 16'(16'h1000 * (k + 1));
    return 16'(rom_slope(s) + f + rom_y0(s));
  endfunction

  // ROM model: one-cycle response.
  logic        rom_v = 1'b0;
  logic [15:0] rom_y0_q = '0;
  logic [15:0] rom_sl_q = '0;
  always @(posedge clk) begin
    rom_v    <= bus.rom_valid_o;
    rom_y0_q <= rom_y0(bus.rom_seg_o);
    rom_sl_q <= rom_slope(bus.rom_seg_o);
  end
  assign bus.rom_valid_i = rom_v | inj_rom;
  assign bus.rom_y0_i    = rom_y0_q;
  assign bus.rom_slope_i = rom_sl_q;

  // MAC model: three-cycle latency.
  logic [2:0]  mac_v = '0;
  logic [15:0] mac_r [3];
  always @(posedge clk) begin
    mac_v    <= {mac_v[1:0], bus.mac_valid_o};
    mac_r[0] <= 16'(bus.mac_a_o + bus.mac_b_o + bus.mac_c_o);
    mac_r[1] <= mac_r[0];
    mac_r[2] <= mac_r[1];
  end
  assign bus.mac_valid_i = mac_v[2] | inj_mac;
  assign bus.mac_res_i   = mac_r[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [2:0] seg, input logic [15:0] frac);
    bus.req_seg_i[3*k +: 3]    = seg;
    bus.req_frac_i[16*k +: 16] = frac;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn  = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_seg_i   = '0;
    bus.req_frac_i  = '0;
    for (int k = 0; k < 4; k++) set_req(k, 3'(k), 16'(16'h1000 * (k + 1)));

    // Reset with requests pending
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", bus.req_ready_o, 4'b0000);
    chk("rst_rom_valid", bus.rom_valid_o, 1'b0);
    chk("rst_mac_valid", bus.mac_valid_o, 1'b0);
    chk("rst_res_valid", bus.res_valid_o, 4'b0000);
    chk("rst_res_data", bus.res_data_o, 16'h0000);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    bus.req_valid_i = '0;

    // Single request, requester 2, seg 3, frac 0x3800
    set_req(2, 3'd3, 16'h3800);
    @(negedge clk);
    bus.req_valid_i = 4'b0100;
    #1;
    chk("a_grant", bus.req_ready_o, 4'b0100);
    chk("a_rom_valid", bus.rom_valid_o, 1'b1);
    chk("a_rom_seg", bus.rom_seg_o, 3'd3);
    @(negedge clk);
    bus.req_valid_i = '0;
    #1;
    chk("a_mac_valid", bus.mac_valid_o, 1'b1);
    chk("a_mac_a", bus.mac_a_o, 16'h3B83);
    chk("a_mac_b", bus.mac_b_o, 16'h3800);
    chk("a_mac_c", bus.mac_c_o, 16'h3D30);
    chk("a_ready_idle", bus.req_ready_o, 4'b0000);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("a_res_early", bus.res_valid_o, 4'b0000);
      chk("a_busy", busy, 1'b1);
    end
    @(negedge clk);
    #1;
    chk("a_res_valid", bus.res_valid_o, 4'b0100);
    chk("a_res_data", bus.res_data_o, 16'hB0B3);
    @(negedge clk);
    #1;
    chk("a_res_done", bus.res_valid_o, 4'b0000);
    chk("a_busy_done", busy, 1'b0);
    chk("a_err", err, 1'b0);
    set_req(2, 3'd2, 16'h3000);

    // All four valid for 8 cycles: round-robin order and back-to-back results
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.req_valid_i = (i < 8) ? 4'hF : 4'h0;
      #1;
      if (i < 8) chk("b_grant", bus.req_ready_o, 4'b0001 << (i % 4));
      if (i >= 5) begin
        chk("b_res_valid", bus.res_valid_o, 4'b0001 << ((i - 5) % 4));
        chk("b_res_data", bus.res_data_o, exp_res((i - 5) % 4));
      end
    end
    @(negedge clk);
    #1;
    chk("b_res_done", bus.res_valid_o, 4'b0000);
    chk("b_err", err, 1'b0);

    // Requesters 1 and 3 with pointer at 2
    do_reset();
    @(negedge clk);
    bus.req_valid_i = 4'b0010;
    #1;
    chk("c_grant_setup", bus.req_ready_o, 4'b0010);
    @(negedge clk);
    bus.req_valid_i = 4'b1010;
    #1;
    chk("c_grant_3", bus.req_ready_o, 4'b1000);
    @(negedge clk);
    #1;
    chk("c_grant_1", bus.req_ready_o, 4'b0010);
    @(negedge clk);
    bus.req_valid_i = 4'hF;
    #1;
    chk("c_ptr_is_2", bus.req_ready_o, 4'b0100);
    @(negedge clk);
    bus.req_valid_i = '0;
    repeat (7) @(negedge clk);
    #1;
    chk("c_err", err, 1'b0);

    // Flush two cycles after three grants
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid_i = 4'b0111;
      #1;
      chk("d_grant", bus.req_ready_o, 4'b0001 << i);
    end
    @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    bus.req_valid_i = 4'b1110;
    flush = 1'b1;
    #1;
    chk("d_flush_no_grant", bus.req_ready_o, 4'b0000);
    chk("d_flush_no_rom", bus.rom_valid_o, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      flush = 1'b0;
      bus.req_valid_i = '0;
      #1;
      chk("d_res_dropped", bus.res_valid_o, 4'b0000);
      chk("d_err", err, 1'b0);
    end
    chk("d_busy_fell", busy, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 4'hF;
    #1;
    chk("d_ptr_reset", bus.req_ready_o, 4'b0001);
    @(negedge clk);
    bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    chk("d_post_res", bus.res_valid_o, 4'b0001);
    chk("d_post_data", bus.res_data_o, exp_res(0));
    chk("d_post_err", err, 1'b0);

    // en_i low with requests pending, then reset mid-stream
    do_reset();
    @(negedge clk);
    bus.req_valid_i = 4'b0011;
    #1;
    chk("e_grant_0", bus.req_ready_o, 4'b0001);
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("e_blocked", bus.req_ready_o, 4'b0000);
    chk("e_no_rom", bus.rom_valid_o, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("e_blocked", bus.req_ready_o, 4'b0000);
    end
    @(negedge clk);
    #1;
    chk("e_res_delivered", bus.res_valid_o, 4'b0001);
    chk("e_blocked_res", bus.req_ready_o, 4'b0000);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("e_grant_1", bus.req_ready_o, 4'b0010);
    @(negedge clk);
    bus.req_valid_i = 4'hF;
    #1;
    chk("e_grant_2", bus.req_ready_o, 4'b0100);
    @(negedge clk);
    #1;
    chk("e_grant_3", bus.req_ready_o, 4'b1000);
    chk("e_busy_pre", busy, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("e_rst_ready", bus.req_ready_o, 4'b0000);
    chk("e_rst_rom", bus.rom_valid_o, 1'b0);
    chk("e_rst_mac", bus.mac_valid_o, 1'b0);
    chk("e_rst_res", bus.res_valid_o, 4'b0000);
    chk("e_rst_busy", busy, 1'b0);
    chk("e_rst_err", err, 1'b0);
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("e_err_after", err, 1'b0);

    // Spurious MAC return with empty tag pipe
    @(negedge clk);
    inj_mac = 1'b1;
    #1;
    chk("f_err_before", err, 1'b0);
    @(negedge clk);
    inj_mac = 1'b0;
    #1;
    chk("f_err_set", err, 1'b1);
    chk("f_no_res", bus.res_valid_o, 4'b0000);
    repeat (5) @(negedge clk);
    #1;
    chk("f_err_sticky", err, 1'b1);
    do_reset();
    #1;
    chk("f_err_cleared", err, 1'b0);

    // Spurious ROM response with stage 1 empty
    @(negedge clk);
    inj_rom = 1'b1;
    #1;
    chk("g_no_mac", bus.mac_valid_o, 1'b0);
    @(negedge clk);
    inj_rom = 1'b0;
    #1;
    chk("g_err_set", err, 1'b1);
    do_reset();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
